uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the CPU data bus, alongside the data memory. It sits downstream of the core's load/store port and uses the same signals as the data memory: we, strobe, addr, wdata, rdata. CPU stores to TXDATA push bytes into a small FIFO. A serial FSM drains the FIFO as 8N1 frames on a single tx pin. The system top ORs rdata with the data memory's rdata, qualified by hit.

Parameters:
BASE_ADDR, 32'h1000_0000, byte address of register block (16-byte aligned)
FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)
DIV_RESET, 16'd868, BAUDDIV reset value (clk cycles per bit)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
we  in  1  bus write enable
strobe  in  4  byte-lane enables, bit i = wdata[8i+7:8i]
addr  in  32  bus byte address
wdata  in  32  write data
rdata  out  32  combinational read data, 0 when hit=0
hit  out  1  combinational, addr[31:4]==BASE_ADDR[31:4]
tx  out  1  serial output, idle high
irq  out  1  registered, high while FIFO empty and FSM idle

Behaviour:
- Register map, offset addr[3:2]:
  - 0 TXDATA, write-only, reads 0.
  - 1 STATUS, read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[11:8] count (zero-extended). Write: a 1 in wdata[3] with strobe[0] clears overflow.
  - 2 BAUDDIV, rw, bits[15:0], per-lane writes via strobe[1:0], upper bits read 0.
  - 3 reserved, reads 0, writes ignored.
- A write is effective only when we & hit.
- TXDATA push: we & hit & offset 0 & strobe[0] pushes wdata[7:0]. Other lanes are ignored.
  - Push when full: data dropped, overflow set at the same edge, FIFO unchanged.
  - Push and pop on the same edge with FIFO neither empty nor full: both occur, count unchanged.
  - Full is evaluated before that edge's pop. A push while full is dropped even if a pop occurs on the same edge.
- Reset values: tx=1, irq=1, FIFO empty, count=0, overflow=0, BAUDDIV=DIV_RESET, FSM=IDLE, baud counter=0. rdata/hit are combinational and carry no reset state.
- FSM states: IDLE, START, DATA, STOP. tx is registered and driven from the state and shift register.
  - IDLE: tx=1. If the FIFO is non-empty at an edge: pop the head into shift reg, latch eff_div = (BAUDDIV==0 ? 1 : BAUDDIV), go to START.
  - START: tx=0 for eff_div cycles.
  - DATA: tx=shift[0], LSB first, 8 bits of eff_div cycles each, shift right per bit.
  - STOP: tx=1 for eff_div cycles, then IDLE.
- Timing: a push sampled at edge N lets the FSM pop at edge N+1, and tx falls after edge N+1.
  - Frame = 10*eff_div cycles.
  - One mandatory IDLE cycle between frames, so back-to-back frames start 10*eff_div+1 cycles apart.
- BAUDDIV writes mid-frame do not affect the current frame. They take effect at the next frame start.
- Baud counter counts 0..eff_div-1 and wraps at each bit boundary. Bit index counts 0..7.
- irq = empty & (next state IDLE), registered.
- Reset asserted mid-frame aborts immediately: tx=1 on the next cycle, FIFO contents discarded.

Decomposition:
- Shared package uart_pkg:
  - Register offsets: OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_BAUDDIV=2'd2.
  - STATUS bit positions.
  - FSM state encoding, 2-bit enum.
- One sub-module sync_fifo (params WIDTH=8, DEPTH):
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Count is $clog2(DEPTH)+1 bits; uart_tx_mmio zero-extends it into STATUS[11:8].
  - The FIFO itself enforces drop-on-full and ignore-pop-on-empty.

Test Plan:
- Reset then idle: rst high 2 cycles → tx=1, irq=1. Read STATUS → 32'h0000_0002; read BAUDDIV → 32'd868.
- Single frame: write BAUDDIV=4, then TXDATA=8'hA5 at edge N → tx low from N+1 for 4 cycles. Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles. STATUS.busy=1 during the frame; irq=1 after.
- Back-to-back plus strobe: BAUDDIV=2, push 8'h55 and 8'h0F in consecutive cycles → second start bit begins exactly 21 cycles after the first. A write to TXDATA with strobe=4'b0010 pushes nothing (count unchanged).
- Overflow: BAUDDIV=100, push 10 bytes 1..10 → STATUS.overflow=1, count=8 or 7 depending on whether the first pop has occurred. Serial output is bytes 1..9 in order with one byte dropped. Writing STATUS=32'h8 clears overflow.
- Divisor edge cases: BAUDDIV=0 → 1-cycle bits, 10-cycle frame. Rewriting BAUDDIV=8 mid-frame leaves the current frame at 1-cycle bits; the next frame uses 8.
- Decode and reset abort: addr=BASE_ADDR+16 → hit=0, rdata=0, no side effects. Asserting rst during the DATA state → tx=1 next cycle, STATUS=32'h2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds register offsets (addr[3:2]), STATUS bit positions, the serial FSM
// state encoding and the divisor-sanitising helper used when a frame starts.
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int unsigned STATUS_FULL    = 0;
  localparam int unsigned STATUS_EMPTY   = 1;
  localparam int unsigned STATUS_BUSY    = 2;
  localparam int unsigned STATUS_OVF     = 3;
  localparam int unsigned STATUS_CNT_LSB = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // A divisor of zero would stall the bit timer, so treat it as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk, rst       clock and synchronous reset (empties the FIFO)
//   push, wdata    write request; ignored while full
//   pop, rdata     read request; ignored while empty; rdata shows the head
//   full, empty    occupancy flags, evaluated before the current edge
//   count          number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    rdata   = mem_q[rd_ptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   we, strobe    bus write enable and byte-lane enables
//   addr, wdata   bus byte address and write data
//   rdata         combinational read data, zero when not hit
//   hit           combinational block select (addr[31:4] matches BASE_ADDR)
//   tx            registered serial output, idle high
//   irq           registered, high while the FIFO is empty and the FSM idles
// Registers (addr[3:2]): 0 TXDATA (wo), 1 STATUS, 2 BAUDDIV, 3 reserved.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned  FIFO_DEPTH = 8,
  parameter logic [15:0]  DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  strobe,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic [1:0]  offset;
  logic        wr_en, push, ovf_clr, div_wr;

  // FIFO interface
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     count_ext;

  // Register state
  logic [15:0] bauddiv_q;
  logic        overflow_q;

  // Serial FSM state
  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;
  logic        bit_done;

  logic unused_bits;
  assign unused_bits = ^{strobe[3:2], wdata[31:16], addr[1:0]};

  always_comb begin
    hit     = (addr[31:4] == BASE_ADDR[31:4]);
    offset  = addr[3:2];
    wr_en   = we & hit;
    push    = wr_en & (offset == OFF_TXDATA) & strobe[0];
    ovf_clr = wr_en & (offset == OFF_STATUS) & strobe[0] & wdata[STATUS_OVF];
    div_wr  = wr_en & (offset == OFF_BAUDDIV);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow looks at full before this edge's pop, matching the FIFO's own drop rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      bauddiv_q  <= DIV_RESET;
      overflow_q <= 1'b0;
    end else begin
      if (push && fifo_full) overflow_q <= 1'b1;
      else if (ovf_clr)      overflow_q <= 1'b0;
      if (div_wr && strobe[0]) bauddiv_q[7:0]  <= wdata[7:0];
      if (div_wr && strobe[1]) bauddiv_q[15:8] <= wdata[15:8];
    end
  end

  // Read mux
  always_comb begin
    rdata     = '0;
    count_ext = 32'(fifo_count);
    if (hit) begin
      case (offset)
        OFF_STATUS: begin
          rdata[STATUS_FULL]                     = fifo_full;
          rdata[STATUS_EMPTY]                    = fifo_empty;
          rdata[STATUS_BUSY]                     = (state_q != StIdle);
          rdata[STATUS_OVF]                      = overflow_q;
          rdata[STATUS_CNT_LSB+3:STATUS_CNT_LSB] = count_ext[3:0];
        end
        OFF_BAUDDIV: rdata = {16'h0000, bauddiv_q};
        default:     rdata = '0;
      endcase
    end
  end

  // Serial FSM: next state and registered outputs
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    fifo_pop   = 1'b0;
    bit_done   = (baud_cnt_q == div_q - 16'd1);

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rdata;
          div_d      = eff_div(bauddiv_q);
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = StData;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // tx follows the state being entered so the start bit appears right after the pop edge.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    irq_d = fifo_empty & (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      div_q      <= 16'd1;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a frame-position reference model is
// compared against tx/irq/hit/rdata on every falling edge, plus directed
// scenarios with hand-computed expectations.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam int          NSAMP = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  strobe = 4'h0;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        hit, tx, irq;

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd868)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .strobe (strobe),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .tx     (tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is described only by its byte, divisor and elapsed cycle count k;
  // tx is derived from k / div (0 = start, 1..8 = data LSB first, 9 = stop).
  logic [7:0]  mq[$];
  bit          m_valid = 0;
  bit          m_ovf, m_active, m_irq;
  logic [15:0] m_div;
  logic [7:0]  m_byte;
  int          m_fdiv, m_k;
  bit          m_empty_pre, m_full_pre, m_wr;

  function automatic bit in_block(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd16);
  endfunction

  function automatic logic m_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_k / m_fdiv;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (!in_block(a)) return r;
    if (a[3:2] == 2'd1) begin
      r[0]    = (mq.size() == DEPTH);
      r[1]    = (mq.size() == 0);
      r[2]    = m_active;
      r[3]    = m_ovf;
      r[11:8] = 4'(mq.size());
    end else if (a[3:2] == 2'd2) begin
      r = {16'h0, m_div};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_active = 0; m_k = 0; m_fdiv = 1; m_irq = 1; m_byte = 8'h0;
      m_div = 16'd868;
      m_valid = 1;
    end else if (m_valid) begin
      m_empty_pre = (mq.size() == 0);
      m_full_pre  = (mq.size() == DEPTH);
      m_wr        = we && in_block(addr);
      if (!m_active) begin
        if (!m_empty_pre) begin
          m_byte   = mq.pop_front();
          m_active = 1;
          m_k      = 0;
          m_fdiv   = (m_div == 16'd0) ? 1 : int'(m_div);
        end
      end else begin
        m_k++;
        if (m_k == 10 * m_fdiv) m_active = 0;
      end
      if (m_wr && addr[3:2] == 2'd0 && strobe[0]) begin
        if (m_full_pre) m_ovf = 1;
        else mq.push_back(wdata[7:0]);
      end
      if (m_wr && addr[3:2] == 2'd1 && strobe[0] && wdata[3]) m_ovf = 0;
      if (m_wr && addr[3:2] == 2'd2) begin
        if (strobe[0]) m_div[7:0]  = wdata[7:0];
        if (strobe[1]) m_div[15:8] = wdata[15:8];
      end
      m_irq = m_empty_pre && !m_active;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx", 32'(tx), 32'(m_tx()));
      check("irq", 32'(irq), 32'(m_irq));
      check("hit", 32'(hit), 32'(in_block(addr)));
      check("rdata", rdata, m_rdata(addr));
    end
  end

  // ---------------- helpers ----------------
  logic samp [NSAMP];
  logic [31:0] stat20;
  logic        irq45;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; strobe = s; we = 1'b1;
    tick();
    we = 1'b0; strobe = 4'h0;
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a; we = 1'b0;
    @(negedge clk);
    check(name, rdata, exp);
    tick();
  endtask

  // samp[i] holds tx after the i-th edge following the call.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      samp[i] = tx;
      if (i == 20) stat20 = rdata;
      if (i == 45) irq45 = irq;
      tick();
    end
  endtask

  function automatic int find_low(input int from);
    for (int i = from; i < NSAMP; i++) if (samp[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [7:0] decode(input int s, input int d);
    logic [7:0] b;
    b = 8'h0;
    if (s < 0) return b;
    for (int j = 0; j < 8; j++) if (s + (j + 1) * d < NSAMP) b[j] = samp[s + (j + 1) * d];
    return b;
  endfunction

  task automatic rx_byte(input int d, output logic [7:0] b, output bit ok);
    ok = 0;
    b = 8'h0;
    for (int t = 0; t < 20 * d + 10; t++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) return;
    repeat (d / 2) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      repeat (d) @(negedge clk);
      b[j] = tx;
    end
    repeat (d) @(negedge clk);
    if (tx !== 1'b1) ok = 0;
  endtask

  // ---------------- stimulus ----------------
  string       exp_s;
  int          nmis, s1, s2;
  logic [7:0]  rb;
  bit          rok;

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd1);
    read_check(BASE + 32'h4, 32'h0000_0002, "reset_status");
    read_check(BASE + 32'h8, 32'd868, "reset_bauddiv");

    // Single frame, div 4, byte A5
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    addr = BASE + 32'h4;
    bus_write(BASE, 32'hA5, 4'b0001);
    addr = BASE + 32'h4;
    capture(50);
    exp_s = {"1", "0000", "1111", "0000", "1111", "0000", "0000", "1111", "0000", "1111", "1111"};
    nmis = 0;
    for (int i = 0; i < 41; i++) if (samp[i] !== (exp_s[i] == "1")) nmis++;
    check("frame_a5_mismatches", 32'(nmis), 32'd0);
    check("frame_a5_idle_after", 32'(samp[41]), 32'd1);
    check("busy_mid_frame", stat20 & 32'h4, 32'h4);
    check("irq_after_frame", 32'(irq45), 32'd1);

    // Lane-1-only TXDATA write pushes nothing
    bus_write(BASE, 32'h0000_7700, 4'b0010);
    read_check(BASE + 32'h4, 32'h0000_0002, "strobe_lane1_no_push");

    // Back-to-back frames, div 2
    bus_write(BASE + 32'h8, 32'd2, 4'b0011);
    bus_write(BASE, 32'h55, 4'b0001);
    bus_write(BASE, 32'h0F, 4'b0001);
    capture(60);
    s1 = find_low(0);
    s2 = find_low(s1 + 20);
    check("b2b_first_start", 32'(s1), 32'd0);
    check("b2b_gap", 32'(s2 - s1), 32'd21);
    check("b2b_byte0", 32'(decode(s1, 2)), 32'h55);
    check("b2b_byte1", 32'(decode(s2, 2)), 32'h0F);
    tick();

    // Overflow: ten pushes into an eight-entry FIFO while a slow frame runs
    bus_write(BASE + 32'h8, 32'd100, 4'b0011);
    for (int i = 1; i <= 10; i++) bus_write(BASE, 32'(i), 4'b0001);
    read_check(BASE + 32'h4, 32'h0000_080D, "overflow_status");
    for (int i = 1; i <= 9; i++) begin
      rx_byte(100, rb, rok);
      check("ovf_rx_ok", 32'(rok), 32'd1);
      check("ovf_rx_byte", 32'(rb), 32'(i));
    end
    tick();
    repeat (60) tick();
    bus_write(BASE + 32'h4, 32'h0000_0008, 4'hF);
    read_check(BASE + 32'h4, 32'h0000_0002, "overflow_cleared");

    // Divisor 0 then rewrite to 8 mid-frame
    for (int i = 0; i < 100; i++) begin
      case (i)
        0: begin addr = BASE + 32'h8; wdata = 32'd0;  strobe = 4'b0011; we = 1'b1; end
        1: begin addr = BASE;         wdata = 32'h3C; strobe = 4'b0001; we = 1'b1; end
        2: begin addr = BASE + 32'h8; wdata = 32'd8;  strobe = 4'b0011; we = 1'b1; end
        3: begin addr = BASE;         wdata = 32'hC3; strobe = 4'b0001; we = 1'b1; end
        default: addr = BASE + 32'h4;
      endcase
      tick();
      we = 1'b0; strobe = 4'h0;
      samp[i] = tx;
    end
    s1 = find_low(0);
    s2 = find_low(s1 + 10);
    check("div0_start", 32'(s1), 32'd2);
    check("div0_next_start", 32'(s2), 32'd13);
    check("div0_byte", 32'(decode(s1, 1)), 32'h3C);
    check("div8_byte", 32'(decode(s2, 8)), 32'hC3);

    // Out-of-block access has no effect
    addr = BASE + 32'h10; wdata = 32'h41; strobe = 4'hF; we = 1'b1;
    @(negedge clk);
    check("decode_hit", 32'(hit), 32'd0);
    check("decode_rdata", rdata, 32'h0);
    tick();
    we = 1'b0; strobe = 4'h0;
    addr = BASE - 32'h4;
    @(negedge clk);
    check("decode_below_hit", 32'(hit), 32'd0);
    tick();
    read_check(BASE + 32'h4, 32'h0000_0002, "decode_no_push");

    // Reset in the middle of the data bits
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    bus_write(BASE, 32'hAA, 4'b0001);
    bus_write(BASE, 32'hBB, 4'b0001);
    bus_write(BASE, 32'hCC, 4'b0001);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", 32'(tx), 32'd1);
    read_check(BASE + 32'h4, 32'h0000_0002, "abort_status");
    repeat (20) tick();

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      int r, off;
      r = $urandom_range(0, 299);
      if (r == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        off    = $urandom_range(0, 3);
        addr   = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) addr = BASE + 32'h10 * 32'($urandom_range(1, 3));
        we     = ($urandom_range(0, 2) == 0);
        strobe = 4'($urandom_range(0, 15));
        wdata  = $urandom;
        if (off == 2) wdata = 32'($urandom_range(0, 3));
        tick();
        we = 1'b0; strobe = 4'h0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
